apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB and CPU address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB and CPU data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum number of ACCESS cycles to wait for pready.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 pclk  input  1  bus clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req  input  1  CPU transfer request; sampled only in IDLE.
REQ-008 we  input  1  CPU write (1) or read (0).
REQ-009 addr  input  ADDR_WIDTH  CPU address.
REQ-010 wdata  input  DATA_WIDTH  CPU write data.
REQ-011 wstrb  input  4  CPU byte strobes.
REQ-012 rdata  output  DATA_WIDTH  read data; valid while done=1.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  completion status; valid while done=1.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 paddr, pdata  output  ADDR_WIDTH, DATA_WIDTH  APB address and write data.
REQ-017 psel, penable, pwrite  output  1 each  APB control signals.
REQ-018 pstb  output  4  APB byte strobes.
REQ-019 prdata  input  DATA_WIDTH  APB read data.
REQ-020 pready, perr  input  1 each  APB completion and slave error.
REQ-021 apb_perr  output  1  sticky bus error, routed to the interrupt controller's APB_perr input.
REQ-022 err_clr  input  1  clears apb_perr.

Function
REQ-023 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-024 In IDLE, psel and penable SHALL be 0; when req=1, addr/wdata/wstrb/we SHALL be captured and the FSM SHALL go to SETUP.
REQ-025 SETUP SHALL last exactly one cycle with psel=1 and penable=0, then go to ACCESS.
REQ-026 In ACCESS, psel=1 and penable=1; paddr, pdata, pwrite and pstb SHALL hold their captured values until ACCESS is left.
REQ-027 pstb SHALL equal the captured wstrb for writes and 4'b0000 for reads.
REQ-028 ACCESS with pready=1 SHALL return to IDLE.
  - Next cycle: done=1 and err equals the sampled perr.
  - rdata is loaded from prdata on reads and unchanged on writes.
REQ-029 The timeout counter SHALL be cleared on SETUP and increment each ACCESS cycle with pready=0.
REQ-030 When the timeout counter reaches TIMEOUT, the FSM SHALL abort to IDLE with done=1, err=1 and rdata unchanged on the next cycle.
REQ-031 If pready=1 in the same cycle as the timeout terminal count, pready SHALL take precedence.
REQ-032 apb_perr SHALL set on any completion with err=1 and clear on err_clr; simultaneous set and clear SHALL leave it set.
REQ-033 done SHALL coincide with the first IDLE cycle; a req in that cycle SHALL be accepted.
  - Minimum three cycles per transfer.
REQ-034 Latency from req to done SHALL be 3 cycles with zero-wait pready, plus one cycle per wait state.
REQ-035 A req arriving while busy=1 SHALL be ignored; the CPU holds it until done.

Reset
REQ-036 On rst=1, regardless of state, outputs SHALL go immediately to the following values:
  - state IDLE;
  - psel, penable, pwrite, done, err, apb_perr, busy = 0;
  - paddr, pdata, rdata = 0; pstb = 0;
  - timeout counter = 0.
REQ-037 Reset mid-transfer SHALL abandon the transfer with no done pulse.
REQ-038 After rst deasserts, the first req SHALL be accepted on the next rising edge.

Structure
REQ-039 The shared package apb_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS), the strobe width (4) and the default TIMEOUT.
REQ-040 The timeout counter SHALL be a separate sub-module, apb_timeout, with clear, enable and expired.
  - Its width is $clog2(TIMEOUT+1).

Verification
REQ-041 Write, zero-wait: addr=0x20000000, wdata=0xDEADBEEF, wstrb=0xF, pready on first ACCESS cycle -> psel at cycle 1, penable at cycle 2, done=1 and err=0 at cycle 3, pstb=0xF.
REQ-042 Read, one wait state (interrupt-controller-style pready), prdata=0x00000003 -> done at cycle 4, rdata=0x00000003, pstb=0.
REQ-043 pready never asserted, TIMEOUT=4 -> abort after 4 ACCESS cycles, done=1, err=1, apb_perr=1 until err_clr.
REQ-044 pready=1 with perr=1 -> err=1 and apb_perr=1; err_clr pulsed in the same cycle as a new error -> apb_perr stays 1.
REQ-045 rst asserted during ACCESS -> psel and penable drop to 0 immediately, no done; a following req completes normally.
REQ-046 Back-to-back: req held high across two writes -> second SETUP in the cycle after done.
  - paddr stable throughout each ACCESS.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared state encoding, strobe width and default timeout for the APB master
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam int STRB_W = 4;
  localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/apb_master_if.sv
// apb_master_if: APB bus signals between the master and a slave
interface apb_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic [apb_pkg::STRB_W-1:0] pstb;
  logic psel, penable, pwrite, pready, perr;
  modport master (output paddr, pdata, pstb, psel, penable, pwrite, input prdata, pready, perr);
  modport slave (input paddr, pdata, pstb, psel, penable, pwrite, output prdata, pready, perr);
endinterface

// File: rtl/apb_timeout.sv
// apb_timeout: ACCESS wait counter; expired flags the increment that reaches TIMEOUT
module apb_timeout #(
  parameter int TIMEOUT = apb_pkg::DEF_TIMEOUT
) (
  input  logic pclk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end
  assign expired = enable && cnt == LAST;
endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding CPU-to-APB bridge with timeout and sticky error flag
module apb_master import apb_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic pclk,
  input  logic rst,
  input  logic req,
  input  logic we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic err_clr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic done,
  output logic err,
  output logic busy,
  output logic apb_perr,
  apb_master_if.master apb
);
  state_t state, nxt;
  logic expired, fin, fail;
  apb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .pclk(pclk),
    .rst(rst),
    .clear(state == SETUP),
    .enable(state == ACCESS && !apb.pready),
    .expired(expired)
  );
  // pready wins over the terminal count because the counter is only enabled without pready
  always_comb begin
    fin = state == ACCESS && (apb.pready || expired);
    fail = apb.pready ? apb.perr : 1'b1;
    nxt = state == IDLE ? (req ? SETUP : IDLE) : state == SETUP ? ACCESS : fin ? IDLE : ACCESS;
  end
  assign busy = state != IDLE;
  assign apb.psel = busy;
  assign apb.penable = state == ACCESS;
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      err <= 1'b0;
      apb_perr <= 1'b0;
      rdata <= '0;
      apb.paddr <= '0;
      apb.pdata <= '0;
      apb.pwrite <= 1'b0;
      apb.pstb <= '0;
    end else begin
      done <= fin;
      apb_perr <= (fin && fail) || (apb_perr && !err_clr);
      if (fin) err <= fail;
      if (fin && apb.pready && !apb.pwrite) rdata <= apb.prdata;
      if (state == IDLE && req) begin
        apb.paddr <= addr;
        apb.pdata <= wdata;
        apb.pwrite <= we;
        apb.pstb <= we ? wstrb : '0;
      end
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized scenario bench for apb_master against a transfer-level model
module tb_apb_master;
  localparam int T = 4;
  logic pclk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, err_clr = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic done, err, busy, apb_perr;
  int checks = 0, errors = 0;
  int lat, acc, x_lat, x_acc;
  logic su, st, pw, e, ape, x_e, x_ape, m_ape;
  logic [31:0] pa, pd, rd, x_rd, m_rd;
  logic [3:0] ps;

  apb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(T)) dut (
    .pclk(pclk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .err_clr(err_clr), .rdata(rdata), .done(done), .err(err), .busy(busy), .apb_perr(apb_perr),
    .apb(bus)
  );

  always #5 pclk = ~pclk;

  // Expected outcome of one transfer from the rules: timing, status, read data, sticky flag
  task automatic model_xfer(input logic w, input int waits, input logic pe, input logic [31:0] prd, input logic clr);
    logic to;
    to = waits >= T;
    x_lat = to ? T + 2 : waits + 3;
    x_acc = to ? T : waits + 1;
    x_e = to | pe;
    if (!to && !w) m_rd = prd;
    x_rd = m_rd;
    m_ape = (m_ape & ~clr) | x_e;
    x_ape = m_ape;
  endtask

  // Starts at a negedge with the DUT able to accept; plays the slave and records observations
  task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int waits, input logic pe, input logic [31:0] prd, input logic clr);
    logic rdy;
    req = 1'b1; we = w; addr = a; wdata = d; wstrb = s;
    lat = -1; acc = 0; su = 1'b0; st = 1'b1;
    pa = '0; pd = '0; pw = 1'b0; ps = '0; e = 1'b0; rd = '0; ape = 1'b0;
    for (int c = 1; c <= 3 * T + 10 && lat < 0; c++) begin
      @(negedge pclk);
      if (c == 1) begin
        su = bus.psel && !bus.penable;
        pa = bus.paddr; pd = bus.pdata; pw = bus.pwrite; ps = bus.pstb;
      end else if (bus.psel && {bus.paddr, bus.pdata, bus.pwrite, bus.pstb} !== {pa, pd, pw, ps}) st = 1'b0;
      if (bus.psel && bus.penable) acc++;
      if (done) begin lat = c; e = err; rd = rdata; ape = apb_perr; end
      rdy = bus.psel && bus.penable && (acc - 1 == waits);
      bus.pready = rdy;
      bus.perr = rdy ? pe : 1'($urandom);
      bus.prdata = rdy ? prd : $urandom;
      err_clr = clr && bus.psel && bus.penable && (rdy || acc == T);
      if (!done) begin
        addr = $urandom; wdata = $urandom; we = 1'($urandom); wstrb = 4'($urandom);
      end
    end
    req = 1'b0; bus.pready = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge pclk); @(negedge pclk);
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite, done, err, apb_perr, busy} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000000", {bus.psel, bus.penable, bus.pwrite, done, err, apb_perr, busy});
    end
    checks++;
    if ({bus.paddr, bus.pdata, rdata, bus.pstb} !== 100'b0) begin
      errors++; $display("FAIL reset_data paddr=%h pdata=%h rdata=%h pstb=%h want all 0", bus.paddr, bus.pdata, rdata, bus.pstb);
    end
    rst = 1'b0; m_rd = '0; m_ape = 1'b0;
  endtask

  task automatic test_write_zero_wait();
    model_xfer(1'b1, 0, 1'b0, 32'h0, 1'b0);
    run_xfer(1'b1, 32'h2000_0000, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (lat !== 3 || acc !== 1 || su !== 1'b1 || st !== 1'b1) begin
      errors++; $display("FAIL wr0_timing lat=%0d acc=%0d setup=%b stable=%b want 3 1 1 1", lat, acc, su, st);
    end
    checks++;
    if ({pa, pd, pw, ps} !== {32'h2000_0000, 32'hDEAD_BEEF, 1'b1, 4'hF}) begin
      errors++; $display("FAIL wr0_bus got %h %h %b %h want 20000000 deadbeef 1 f", pa, pd, pw, ps);
    end
    checks++;
    if ({e, rd, ape} !== {x_e, x_rd, x_ape}) begin
      errors++; $display("FAIL wr0_done err=%b rdata=%h perr=%b want %b %h %b", e, rd, ape, x_e, x_rd, x_ape);
    end
  endtask

  task automatic test_read_wait();
    model_xfer(1'b0, 1, 1'b0, 32'h3, 1'b0);
    @(negedge pclk);
    run_xfer(1'b0, 32'h4000_0010, 32'h1234_5678, 4'hA, 1, 1'b0, 32'h3, 1'b0);
    checks++;
    if (lat !== 4 || acc !== 2 || su !== 1'b1 || st !== 1'b1) begin
      errors++; $display("FAIL rd1_timing lat=%0d acc=%0d setup=%b stable=%b want 4 2 1 1", lat, acc, su, st);
    end
    checks++;
    if ({pa, pw, ps} !== {32'h4000_0010, 1'b0, 4'h0}) begin
      errors++; $display("FAIL rd1_bus got %h %b %h want 40000010 0 0", pa, pw, ps);
    end
    checks++;
    if ({e, rd, ape} !== {1'b0, 32'h3, 1'b0}) begin
      errors++; $display("FAIL rd1_done err=%b rdata=%h perr=%b want 0 00000003 0", e, rd, ape);
    end
  endtask

  task automatic test_timeout();
    model_xfer(1'b0, T, 1'b0, 32'h0, 1'b0);
    @(negedge pclk);
    run_xfer(1'b0, 32'h8, 32'h0, 4'h0, T, 1'b0, 32'h0, 1'b0);
    checks++;
    if (lat !== T + 2 || acc !== T || {e, rd, ape} !== {1'b1, x_rd, 1'b1}) begin
      errors++; $display("FAIL timeout lat=%0d acc=%0d err=%b rdata=%h perr=%b want %0d %0d 1 %h 1", lat, acc, e, rd, ape, T + 2, T, x_rd);
    end
    repeat (3) @(negedge pclk);
    checks++;
    if (apb_perr !== 1'b1) begin errors++; $display("FAIL timeout_sticky apb_perr=%b want 1", apb_perr); end
    err_clr = 1'b1; @(negedge pclk); err_clr = 1'b0; m_ape = 1'b0;
    checks++;
    if (apb_perr !== 1'b0) begin errors++; $display("FAIL timeout_clear apb_perr=%b want 0", apb_perr); end
  endtask

  task automatic test_perr();
    model_xfer(1'b0, 0, 1'b1, 32'h55AA_0F0F, 1'b0);
    run_xfer(1'b0, 32'h100, 32'h0, 4'h0, 0, 1'b1, 32'h55AA_0F0F, 1'b0);
    checks++;
    if ({e, rd, ape} !== {x_e, x_rd, x_ape} || lat !== 3) begin
      errors++; $display("FAIL perr_first lat=%0d err=%b rdata=%h perr=%b want 3 %b %h %b", lat, e, rd, ape, x_e, x_rd, x_ape);
    end
    model_xfer(1'b1, 2, 1'b1, 32'h0, 1'b1);
    run_xfer(1'b1, 32'h104, 32'hCAFE, 4'h3, 2, 1'b1, 32'h0, 1'b1);
    checks++;
    if ({e, rd, ape} !== {x_e, x_rd, x_ape}) begin
      errors++; $display("FAIL perr_set_clr err=%b rdata=%h perr=%b want %b %h %b", e, rd, ape, x_e, x_rd, x_ape);
    end
    model_xfer(1'b1, 0, 1'b0, 32'h0, 1'b1);
    run_xfer(1'b1, 32'h108, 32'hBEEF, 4'h1, 0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({e, ape} !== {1'b0, x_ape}) begin
      errors++; $display("FAIL perr_clr_clean err=%b perr=%b want 0 %b", e, ape, x_ape);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    @(negedge pclk);
    req = 1'b1; we = 1'b1; addr = 32'h300; wdata = 32'h1; wstrb = 4'hF;
    @(negedge pclk); @(negedge pclk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.psel, bus.penable, busy, done} !== 4'b0) begin
      errors++; $display("FAIL rst_mid psel=%b penable=%b busy=%b done=%b want 0 0 0 0", bus.psel, bus.penable, busy, done);
    end
    saw_done = 1'b0;
    repeat (3) begin @(negedge pclk); saw_done |= done; end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done saw done=%b want 0", saw_done); end
    rst = 1'b0; m_rd = '0; m_ape = 1'b0;
    model_xfer(1'b0, 1, 1'b0, 32'h0BAD_F00D, 1'b0);
    run_xfer(1'b0, 32'h304, 32'h0, 4'h0, 1, 1'b0, 32'h0BAD_F00D, 1'b0);
    checks++;
    if (lat !== x_lat || su !== 1'b1 || {e, rd, ape} !== {x_e, x_rd, x_ape}) begin
      errors++; $display("FAIL rst_after lat=%0d setup=%b err=%b rdata=%h perr=%b want %0d 1 %b %h %b", lat, su, e, rd, ape, x_lat, x_e, x_rd, x_ape);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge pclk);
    model_xfer(1'b1, 1, 1'b0, 32'h0, 1'b0);
    run_xfer(1'b1, 32'h500, 32'hA5A5_A5A5, 4'hC, 1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (lat !== 4 || st !== 1'b1 || pa !== 32'h500 || ps !== 4'hC) begin
      errors++; $display("FAIL b2b_first lat=%0d stable=%b paddr=%h pstb=%h want 4 1 00000500 c", lat, st, pa, ps);
    end
    model_xfer(1'b1, 0, 1'b0, 32'h0, 1'b0);
    run_xfer(1'b1, 32'h504, 32'h5A5A_5A5A, 4'h3, 0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (lat !== 3 || su !== 1'b1 || st !== 1'b1 || {pa, pd, ps} !== {32'h504, 32'h5A5A_5A5A, 4'h3}) begin
      errors++; $display("FAIL b2b_second lat=%0d setup=%b stable=%b paddr=%h pdata=%h pstb=%h want 3 1 1 00000504 5a5a5a5a 3", lat, su, st, pa, pd, ps);
    end
  endtask

  task automatic test_random();
    logic w, pe, clr;
    logic [31:0] a, d, prd;
    logic [3:0] s;
    int waits;
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom); pe = ($urandom_range(0, 3) == 0); clr = ($urandom_range(0, 3) == 0);
      a = $urandom; d = $urandom; prd = $urandom; s = 4'($urandom); waits = $urandom_range(0, T + 1);
      repeat ($urandom_range(0, 2)) @(negedge pclk);
      model_xfer(w, waits, pe, prd, clr);
      run_xfer(w, a, d, s, waits, pe, prd, clr);
      checks++;
      if (lat !== x_lat || acc !== x_acc || su !== 1'b1 || st !== 1'b1) begin
        errors++; $display("FAIL rand%0d_timing lat=%0d acc=%0d setup=%b stable=%b want %0d %0d 1 1", i, lat, acc, su, st, x_lat, x_acc);
      end
      checks++;
      if ({pa, pd, pw, ps} !== {a, d, w, w ? s : 4'h0}) begin
        errors++; $display("FAIL rand%0d_bus got %h %h %b %h want %h %h %b %h", i, pa, pd, pw, ps, a, d, w, w ? s : 4'h0);
      end
      checks++;
      if ({e, rd, ape} !== {x_e, x_rd, x_ape}) begin
        errors++; $display("FAIL rand%0d_done err=%b rdata=%h perr=%b want %b %h %b", i, e, rd, ape, x_e, x_rd, x_ape);
      end
    end
  endtask

  initial begin
    bus.pready = 1'b0; bus.perr = 1'b0; bus.prdata = '0;
    m_rd = '0; m_ape = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_timeout();
    test_perr();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
